// File: rtl/ecm_share_arbiter_if.sv
// ecm_share_arbiter_if: request, shared-multiplier and response bus of ecm_share_arbiter
// req_*  : per-requester valid/ready with packed operands (requester i at slice i)
// ecm_*  : registered operands to / combinational result from the shared multiplier
// rsp_*  : single tagged response channel
// slave  : arbiter side; master: requesters, multiplier and response consumer side
interface ecm_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int MANT_W  = 6,
    parameter int OUT_W   = 7,
    parameter int SEL_W   = 3,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*MANT_W-1:0] req_mA;
    logic [NUM_REQ*MANT_W-1:0] req_mB;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic [MANT_W-1:0]         ecm_mA;
    logic [MANT_W-1:0]         ecm_mB;
    logic [SEL_W-1:0]          ecm_sel;
    logic [OUT_W-1:0]          ecm_manti;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [OUT_W-1:0]          rsp_manti;
    modport slave (
        input  req_valid, req_mA, req_mB, req_sel, ecm_manti, rsp_ready,
        output req_ready, ecm_mA, ecm_mB, ecm_sel, rsp_valid, rsp_id, rsp_manti
    );
    modport master (
        output req_valid, req_mA, req_mB, req_sel, ecm_manti, rsp_ready,
        input  req_ready, ecm_mA, ecm_mB, ecm_sel, rsp_valid, rsp_id, rsp_manti
    );
endinterface

// File: rtl/ecm_share_arbiter.sv
// ecm_share_arbiter: round-robin sharing of one combinational error-correction multiplier
// clk, rst : clock and asynchronous active-high reset
// bus      : ecm_share_arbiter_if.slave (requests, shared multiplier, response)
// ECM_SEL_OVERRIDE_EN adds cfg_sel_force/cfg_sel_val, which replace the granted sel at accept
module ecm_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MANT_W  = 6,
    parameter int OUT_W   = 7,
    parameter int SEL_W   = 3,
    parameter int ID_W    = 2
) (
    input logic clk,
    input logic rst,
`ifdef ECM_SEL_OVERRIDE_EN
    input logic             cfg_sel_force,
    input logic [SEL_W-1:0] cfg_sel_val,
`endif
    ecm_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    state_t          state, state_nx;
    logic [ID_W-1:0] rr_ptr, pend_id, grant, idx;
    logic            any_valid, accept_win, accept;
    logic [SEL_W-1:0] sel_in;
    // descending scan so the nearest requester after rr_ptr is written last and wins
    always_comb begin
        grant = '0;
        any_valid = 1'b0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                grant = idx;
                any_valid = 1'b1;
            end
        end
    end
    // rsp_valid is always set in RESP, so the handshake reduces to rsp_ready
    assign accept_win    = !rst && (state == IDLE || (state == RESP && bus.rsp_ready));
    assign accept        = accept_win && any_valid;
    assign bus.req_ready = accept ? NUM_REQ'(1) << grant : '0;
`ifdef ECM_SEL_OVERRIDE_EN
    assign sel_in = cfg_sel_force ? cfg_sel_val : bus.req_sel[grant*SEL_W +: SEL_W];
`else
    assign sel_in = bus.req_sel[grant*SEL_W +: SEL_W];
`endif
    always_comb begin
        state_nx = accept ? EVAL
                 : (state == EVAL) ? RESP
                 : (state == RESP && !bus.rsp_ready) ? RESP
                 : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= ID_W'(NUM_REQ - 1);
            pend_id       <= '0;
            bus.ecm_mA    <= '0;
            bus.ecm_mB    <= '0;
            bus.ecm_sel   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_manti <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                bus.ecm_mA  <= bus.req_mA[grant*MANT_W +: MANT_W];
                bus.ecm_mB  <= bus.req_mB[grant*MANT_W +: MANT_W];
                bus.ecm_sel <= sel_in;
                pend_id     <= grant;
                rr_ptr      <= grant;
            end
            if (state == EVAL) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id    <= pend_id;
                bus.rsp_manti <= bus.ecm_manti;
            end else if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ecm_share_arbiter.sv
// tb_ecm_share_arbiter: directed and randomized checks of ecm_share_arbiter against a transaction model
module tb_ecm_share_arbiter;
    localparam int N  = 4;
    localparam int MW = 6;
    localparam int OW = 7;
    localparam int SW = 3;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecm_share_arbiter_if #(.NUM_REQ(N), .MANT_W(MW), .OUT_W(OW), .SEL_W(SW), .ID_W(IW)) bus();
`ifdef ECM_SEL_OVERRIDE_EN
    logic          cfg_sel_force = 1'b0;
    logic [SW-1:0] cfg_sel_val = '0;
`endif

    ecm_share_arbiter #(.NUM_REQ(N), .MANT_W(MW), .OUT_W(OW), .SEL_W(SW), .ID_W(IW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef ECM_SEL_OVERRIDE_EN
        .cfg_sel_force(cfg_sel_force),
        .cfg_sel_val(cfg_sel_val),
`endif
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // stand-in for the shared multiplier: top OUT_W product bits, low sel bits truncated
    function automatic logic [OW-1:0] mul_ref(logic [MW-1:0] x, logic [MW-1:0] y, logic [SW-1:0] sl);
        logic [2*MW-1:0] p;
        logic [OW-1:0]   r;
        p = (2*MW)'(x) * (2*MW)'(y);
        r = p[2*MW-1 -: OW];
        r = r >> sl;
        r = r << sl;
        return r;
    endfunction

    logic [N-1:0]  vld;
    logic [MW-1:0] a [N];
    logic [MW-1:0] b [N];
    logic [SW-1:0] s [N];
    logic          rdy;
    int            mode;
    logic [N-1:0]  taken;

    always_comb begin
        bus.req_valid = vld;
        bus.rsp_ready = rdy;
        bus.req_mA = '0;
        bus.req_mB = '0;
        bus.req_sel = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_mA[i*MW +: MW] = a[i];
            bus.req_mB[i*MW +: MW] = b[i];
            bus.req_sel[i*SW +: SW] = s[i];
        end
    end
    assign bus.ecm_manti = mul_ref(bus.ecm_mA, bus.ecm_mB, bus.ecm_sel);
    always @(posedge clk) taken <= rst ? '0 : bus.req_valid & bus.req_ready;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [OW-1:0] m;
        logic [MW-1:0] oa;
        logic [MW-1:0] ob;
        logic [SW-1:0] os;
        int            cyc;
    } exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   last = N - 1;
    logic seen = 1'b0;
    logic p_hold = 1'b0;
    logic [IW+OW-1:0] h;
    logic [N-1:0] p_pend = '0;
    logic [2*MW+SW-1:0] p_ops [N];

    // transaction model: one outstanding result at a time, round-robin from the last grant
    always @(negedge clk) begin
        logic [N-1:0] er;
        logic [SW-1:0] se;
        int g;
        bit win;
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            last = N - 1;
            seen = 1'b0;
            p_hold = 1'b0;
            p_pend = '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (p_pend[i]) chk("req_hold", {vld[i], a[i], b[i], s[i]}, {1'b1, p_ops[i]});
            win = q.size() == 0 || (q.size() == 1 && bus.rsp_valid && bus.rsp_ready);
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && vld[(last + k) % N]) g = (last + k) % N;
            er = (win && g >= 0) ? N'(1) << g : '0;
            chk("req_ready", bus.req_ready, er);
            if (q.size() > 0 && q[$].cyc == cyc - 1)
                chk("ecm_ops", {bus.ecm_mA, bus.ecm_mB, bus.ecm_sel}, {q[$].oa, q[$].ob, q[$].os});
            if (p_hold) chk("rsp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_manti}, {1'b1, h});
            if (bus.rsp_valid) begin
                if (q.size() == 0) chk("rsp_spurious", bus.rsp_valid, 0);
                else begin
                    if (!seen) chk("rsp_latency", cyc - q[0].cyc, 2);
                    seen = 1'b1;
                    if (bus.rsp_ready) begin
                        chk("rsp_data", {bus.rsp_id, bus.rsp_manti}, {q[0].id, q[0].m});
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            p_hold = bus.rsp_valid && !bus.rsp_ready;
            h = {bus.rsp_id, bus.rsp_manti};
            if (er != 0) begin
                se = s[g];
`ifdef ECM_SEL_OVERRIDE_EN
                if (cfg_sel_force) se = cfg_sel_val;
`endif
                e.id = IW'(g);
                e.m = mul_ref(a[g], b[g], se);
                e.oa = a[g];
                e.ob = b[g];
                e.os = se;
                e.cyc = cyc;
                q.push_back(e);
                last = g;
            end
            for (int i = 0; i < N; i++) begin
                p_pend[i] = vld[i] && !er[i];
                p_ops[i] = {a[i], b[i], s[i]};
            end
        end
    end

    task automatic new_req(int i);
        vld[i] = 1'b1;
        a[i] = MW'($urandom);
        b[i] = MW'($urandom);
        s[i] = SW'($urandom);
    endtask

    // mode 0: drop after accept; 1: re-request at once; 2: random traffic and back-pressure
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (taken[i]) begin
                if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) new_req(i);
                else vld[i] = 1'b0;
            end else if (mode == 2 && !vld[i] && $urandom_range(3) == 0) new_req(i);
        end
        if (mode == 2) begin
            rdy = $urandom_range(3) != 0;
`ifdef ECM_SEL_OVERRIDE_EN
            cfg_sel_force = 1'($urandom);
            cfg_sel_val = SW'($urandom);
`endif
        end
    endtask

    task automatic drain();
        int n = 0;
        mode = 0;
        rdy = 1'b1;
        tick();
        while (n < 50 && (vld != 0 || bus.rsp_valid)) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 50), 1);
        repeat (3) tick();
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("wait_rsp", bus.rsp_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ids[$];
        int tl[$];
        logic [IW+OW-1:0] h0;
        rdy = 1'b0;
        mode = 0;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            b[i] = '0;
            s[i] = '0;
        end
        vld = '1;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp", {bus.rsp_id, bus.rsp_manti}, 0);
        chk("rst_ecm", {bus.ecm_mA, bus.ecm_mB, bus.ecm_sel}, 0);
        vld = '0;
        tick();
        rst = 1'b0;

        vld[1] = 1'b1;
        a[1] = 6'h2D;
        b[1] = 6'h13;
        s[1] = 3'd2;
        rdy = 1'b1;
        @(negedge clk);
        chk("t1_ready", bus.req_ready, 4'b0010);
        tick();
        @(negedge clk);
        chk("t1_ecm", {bus.ecm_mA, bus.ecm_mB, bus.ecm_sel}, {6'h2D, 6'h13, 3'd2});
        tick();
        @(negedge clk);
        chk("t1_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_manti}, {1'b1, 2'd1, 7'h18});
        drain();

        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 1;
        rdy = 1'b1;
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 40 && ids.size() < 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                ids.push_back(int'(bus.rsp_id));
                tl.push_back(c);
            end
            tick();
        end
        chk("rr_count", ids.size(), 8);
        foreach (ids[k]) chk("rr_order", ids[k], k % N);
        for (int k = 1; k < tl.size(); k++) chk("rr_gap", tl[k] - tl[k-1], 2);
        drain();

        new_req(0);
        rdy = 1'b0;
        wait_rsp();
        h0 = {bus.rsp_id, bus.rsp_manti};
        tick();
        new_req(2);
        new_req(3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_manti}, {1'b1, h0});
            chk("stall_ready", bus.req_ready, 0);
            tick();
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("release_grant", bus.req_ready, 4'b0100);
        drain();

        new_req(1);
        a[1] = 6'h15;
        @(negedge clk);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_eval_valid", bus.rsp_valid, 0);
        chk("rst_eval_ecm", bus.ecm_mA, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_eval_stale", bus.rsp_valid, 0);
        tick();
        new_req(3);
        rdy = 1'b0;
        wait_rsp();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", bus.rsp_valid, 0);
        tick();
        rst = 1'b0;
        mode = 1;
        rdy = 1'b1;
        for (int i = 0; i < N; i++) new_req(i);
        @(negedge clk);
        chk("rst_first_grant", bus.req_ready, 4'b0001);
        drain();

`ifdef ECM_SEL_OVERRIDE_EN
        cfg_sel_force = 1'b1;
        cfg_sel_val = 3'd7;
        new_req(0);
        s[0] = 3'd1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("sel_force", bus.ecm_sel, 7);
        drain();
        cfg_sel_force = 1'b0;
        new_req(2);
        s[2] = 3'd1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("sel_noforce", bus.ecm_sel, 1);
        drain();
`endif

        mode = 2;
        repeat (3000) tick();
        drain();
        chk("final_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
